week6_ex1_rr_encoder: RTL and testbench
=======================================

# week6_ex1_rr_encoder

Sequential 4-to-2 round-robin encoder: the inverse of the 2-to-4 one-hot decoder. It samples a multi-bit request vector, selects one asserted bit by rotating priority, and presents the binary index, plus its one-hot echo, to a downstream consumer over a valid/ready handshake. It sits between request sources (buttons, flags, decoder outputs) and any block that consumes a 2-bit select.

## Interface
- NREQ, 4, number of request lines
- IDXW, 2, index width; must equal clog2(NREQ)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  request vector; any number of bits may be set
- ready  input  1  consumer accepts current index this cycle
- valid  output  1  idx/onehot/multi hold a granted request
- idx  output  IDXW  binary index of granted request line
- onehot  output  NREQ  one-hot decode of idx while valid, all zero otherwise
- multi  output  1  more than one req bit was set at capture
- grant_cnt  output  8  number of completed handshakes, saturates at 255

## Operation
- Internal state: FSM {IDLE, HOLD}; rotating pointer ptr[IDXW-1:0].
- IDLE: valid=0. On a clock edge with req != 0, select the first set bit of req searching ptr, ptr+1, ... modulo NREQ. Register idx, onehot=1<<idx, and multi=(popcount(req)>1). Go to HOLD. With req == 0, stay in IDLE and leave outputs unchanged except valid=0 and onehot=0.
- HOLD: valid=1. idx, onehot, and multi are frozen; req changes are ignored.
  - On a clock edge with ready=1: ptr <= idx+1 (wraps 3->0), grant_cnt increments unless it is 255, go to IDLE.
  - With ready=0: stay in HOLD.
- Rotation guarantees a continuously asserted line waits at most NREQ-1 other grants.
- If req is one-hot and ptr is irrelevant, idx equals the plain binary encoding. A decoder driven by idx reproduces req.
- ready while in IDLE is ignored.
- Reset (async, any time, including mid-HOLD): FSM=IDLE, ptr=0, valid=0, idx=0, onehot=0, multi=0, grant_cnt=0. A pending grant is discarded and not counted.

## Timing
- Capture latency: req sampled at edge k (IDLE), so valid=1 is visible after edge k.
- Handshake: a transfer occurs at the edge where valid=1 and ready=1. valid drops after that edge.
- After a transfer there is one mandatory IDLE cycle. The next capture happens at the following edge, so peak throughput is one grant per 2 cycles.
- ready may be held high permanently. ready may also be asserted before valid; it has no effect until HOLD.
- All outputs are registered; there are no combinational paths from input to output.
- ptr updates only on a transfer, never at capture.

## Structure
- Shared package holds:
  - the state enum {IDLE, HOLD}
  - the NREQ/IDXW constants
  - a function onehot_of(idx) so the decoder and encoder share one definition
- One sub-module is natural: week6_rr_pick. It is purely combinational: given req and ptr, it produces the chosen index and the multi flag. The top-level holds the FSM, registers, and counter.

## Test plan
- Reset then req=4'b0100, ready=1 -> valid=1 one cycle after capture, idx=2, onehot=4'b0100, multi=0; valid=0 next cycle; grant_cnt=1.
- req=4'b1111 held, ready=1 for 8 cycles -> idx sequence 0,1,2,3 with valid on alternate cycles; multi=1 each time; grant_cnt=4.
- req=4'b0011, ready=0 for 5 cycles while req changes to 4'b1000 -> idx stays 0, onehot stays 4'b0001, valid stays 1. Raise ready -> transfer; next grant is idx=3 (ptr=1 rotated to the first set bit).
- ptr=3 after granting idx=2, then req=4'b0001 -> idx=0 (wrap-around search); ptr becomes 1 after the transfer.
- Assert rst mid-HOLD (valid=1, idx=2) -> all outputs 0 immediately, without waiting for a clock; grant_cnt not incremented. After release, req=4'b0010 -> idx=1 (ptr reset to 0).
- 300 back-to-back transfers with req=4'b0001 -> grant_cnt=255 and stays at 255; req=0 throughout IDLE keeps valid=0.

Source files
------------

// File: rtl/week6_ex1_rr_encoder_pkg.sv
// Shared constants, FSM state type and the one-hot helper for the round-robin encoder.
package week6_ex1_rr_encoder_pkg;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDXW = 2;
    localparam int unsigned CNTW = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Single definition of index-to-one-hot, shared by encoder and any downstream decoder.
    function automatic logic [NREQ-1:0] onehot_of(input logic [IDXW-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/week6_ex1_rr_encoder_pick.sv
// Combinational rotating-priority pick: first set request at or after ptr, plus multi-request flag.
module week6_rr_pick
    import week6_ex1_rr_encoder_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [IDXW-1:0] sel_idx_c,
    output logic            multi_c
);

    logic            found;
    logic [IDXW-1:0] cand;

    always_comb begin
        sel_idx_c = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = ptr_i + IDXW'(i);
            if (!found && req_i[cand]) begin
                sel_idx_c = cand;
                found     = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign multi_c = (req_i & (req_i - NREQ'(1))) != '0;

endmodule

// File: rtl/week6_ex1_rr_encoder.sv
// Round-robin 4-to-2 encoder: captures a request, holds the grant until a valid/ready transfer.
module week6_ex1_rr_encoder
    import week6_ex1_rr_encoder_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [IDXW-1:0] idx_o,
    output logic [NREQ-1:0] onehot_o,
    output logic            multi_o,
    output logic [CNTW-1:0] grant_cnt_o
);

    state_e          state_q,  state_d;
    logic [IDXW-1:0] ptr_q,    ptr_d;
    logic            valid_q,  valid_d;
    logic [IDXW-1:0] idx_q,    idx_d;
    logic [NREQ-1:0] onehot_q, onehot_d;
    logic            multi_q,  multi_d;
    logic [CNTW-1:0] cnt_q,    cnt_d;

    logic [IDXW-1:0] pick_idx;
    logic            pick_multi;

    week6_rr_pick u_pick (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .sel_idx_c (pick_idx),
        .multi_c   (pick_multi)
    );

    // Next-state: capture in IDLE, freeze in HOLD, rotate pointer only on transfer.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        multi_d  = multi_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_i != '0) begin
                    state_d  = HOLD;
                    valid_d  = 1'b1;
                    idx_d    = pick_idx;
                    onehot_d = onehot_of(pick_idx);
                    multi_d  = pick_multi;
                end else begin
                    valid_d  = 1'b0;
                    onehot_d = '0;
                end
            end
            HOLD: begin
                if (ready_i) begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    onehot_d = '0;
                    ptr_d    = idx_q + IDXW'(1);
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
            multi_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            multi_q  <= multi_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid_o     = valid_q;
    assign idx_o       = idx_q;
    assign onehot_o    = onehot_q;
    assign multi_o     = multi_q;
    assign grant_cnt_o = cnt_q;

endmodule

// File: tb/tb_week6_ex1_rr_encoder.sv
// Bench for the round-robin encoder: directed scenarios plus random traffic against a cycle model.
module tb_week6_ex1_rr_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic       valid;
    logic [1:0] idx;
    logic [3:0] onehot;
    logic       multi;
    logic [7:0] grant_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_hold;
    int m_ptr;
    int m_idx;
    int m_onehot;
    bit m_multi;
    int m_cnt;

    week6_ex1_rr_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .ready_i     (ready),
        .valid_o     (valid),
        .idx_o       (idx),
        .onehot_o    (onehot),
        .multi_o     (multi),
        .grant_cnt_o (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 0; m_ptr = 0; m_idx = 0; m_onehot = 0; m_multi = 0; m_cnt = 0;
    endtask

    // One clock edge of the behavioural rules, using the inputs present at that edge.
    task automatic model_step();
        if (!m_hold) begin
            if (req != 0) begin
                for (int k = 0; k < 4; k++) begin
                    int j;
                    j = (m_ptr + k) % 4;
                    if (req[j]) begin
                        m_idx = j;
                        break;
                    end
                end
                m_onehot = 1 << m_idx;
                m_multi  = ($countones(req) > 1);
                m_hold   = 1;
            end else begin
                m_onehot = 0;
            end
        end else if (ready) begin
            m_ptr    = (m_idx + 1) % 4;
            if (m_cnt < 255) m_cnt++;
            m_hold   = 0;
            m_onehot = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"},  32'(valid),     32'(m_hold));
        check({tag, ".idx"},    32'(idx),       32'(m_idx));
        check({tag, ".onehot"}, 32'(onehot),    32'(m_onehot));
        check({tag, ".multi"},  32'(multi),     32'(m_multi));
        check({tag, ".cnt"},    32'(grant_cnt), 32'(m_cnt));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; ready = 1'b0;
        model_reset();
        #12;
        compare_all("por");
        check("por.valid_const", 32'(valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single one-hot request
        req = 4'b0100; ready = 1'b1;
        cycle("s1.cap");
        check("s1.idx_const", 32'(idx), 32'd2);
        check("s1.onehot_const", 32'(onehot), 32'h4);
        req = '0;
        cycle("s1.xfer");
        check("s1.valid_drop", 32'(valid), 32'd0);
        check("s1.cnt_const", 32'(grant_cnt), 32'd1);

        // All requests held: rotation 0,1,2,3
        do_reset();
        req = 4'b1111; ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle("s2");
            if (i % 2 == 0) begin
                check("s2.idx_seq", 32'(idx), 32'(i / 2));
                check("s2.multi", 32'(multi), 32'd1);
            end
        end
        check("s2.cnt_const", 32'(grant_cnt), 32'd4);

        // Frozen outputs while stalled, then rotated pick
        do_reset();
        req = 4'b0011; ready = 1'b0;
        cycle("s3.cap");
        req = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            cycle("s3.stall");
            check("s3.idx_frozen", 32'(idx), 32'd0);
            check("s3.oh_frozen", 32'(onehot), 32'h1);
        end
        ready = 1'b1;
        cycle("s3.xfer");
        cycle("s3.cap2");
        check("s3.idx_rot", 32'(idx), 32'd3);

        // Wrap-around search from ptr=3, then ptr=1
        do_reset();
        req = 4'b0100; ready = 1'b1;
        cycle("s4.a"); cycle("s4.b");
        req = 4'b0001;
        cycle("s4.c");
        check("s4.wrap_idx", 32'(idx), 32'd0);
        cycle("s4.d");
        req = 4'b1001;
        cycle("s4.e");
        check("s4.ptr1_idx", 32'(idx), 32'd3);
        cycle("s4.f");

        // Async reset mid-HOLD
        do_reset();
        req = 4'b0100; ready = 1'b0;
        cycle("s5.cap");
        check("s5.held_idx", 32'(idx), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("s5.async");
        check("s5.valid_clr", 32'(valid), 32'd0);
        check("s5.cnt_clr", 32'(grant_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0010; ready = 1'b1;
        cycle("s5.after");
        check("s5.idx_after", 32'(idx), 32'd1);
        cycle("s5.xfer");

        // Counter saturation
        do_reset();
        req = 4'b0001; ready = 1'b1;
        for (int i = 0; i < 600; i++) cycle("s6");
        check("s6.sat", 32'(grant_cnt), 32'd255);
        req = '0;
        for (int i = 0; i < 4; i++) begin
            cycle("s6.idle");
            check("s6.idle_valid", 32'(valid), 32'd0);
        end

        // Random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            req   = 4'($urandom);
            ready = ($urandom_range(0, 2) != 0);
            cycle("rnd");
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
